// File: rtl/latch_if_pkg.sv
// Shared types and helpers for the latch reader.
package latch_if_pkg;

    // Reader state: waiting for enable, counting stable edges, word accepted.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } lr_state_t;

    // Width of the stability counter; covers STABLE up to 15.
    localparam int unsigned STAB_W = 4;

    // Pointer width for a FIFO of n entries, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/latch_reader_fifo.sv
// Small synchronous FIFO with a registered head word and registered flags.
module latch_reader_fifo
    import latch_if_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       valid
);

    localparam int unsigned PTR_W = clog2_min1(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_inc;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    // Qualify requests, next occupancy and next head word.
    always_comb begin
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        rd_inc    = rd_ptr + PTR_W'(1);
        cnt_next  = count + CNT_W'(do_push) - CNT_W'(do_pop);
        head_next = rdata;
        if (do_pop) begin
            if (count > CNT_W'(1)) begin
                head_next = mem[rd_inc];
            end else if (do_push) begin
                head_next = wdata;
            end
        end else if (empty && do_push) begin
            head_next = wdata;
        end
    end

    // Storage array; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy, flags and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            valid  <= 1'b0;
            rdata  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_inc;
            end
            count <= cnt_next;
            full  <= (cnt_next == CNT_W'(DEPTH));
            empty <= (cnt_next == '0);
            valid <= (cnt_next != '0);
            rdata <= head_next;
        end
    end

endmodule

// File: rtl/latch_reader.sv
// Samples a transparent latch and emits one word per settled value change.
module latch_reader
    import latch_if_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STABLE = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   lat_en,
    input  logic [WIDTH-1:0]       lat_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam logic [STAB_W-1:0] STAB_LIM = STAB_W'(STABLE);

    lr_state_t         state;
    logic [WIDTH-1:0]  s_data;
    logic [STAB_W-1:0] stab_cnt;
    logic [STAB_W-1:0] cnt_next;
    logic              match;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;

    // Stability tracking and accept decision for the current edge.
    always_comb begin
        match    = (lat_data == s_data);
        cnt_next = '0;
        if (lat_en && match) begin
            cnt_next = (stab_cnt >= STAB_LIM) ? STAB_LIM : stab_cnt + STAB_W'(1);
        end
        push = lat_en && (state == SETTLE) && (cnt_next == STAB_LIM);
        pop  = out_ready && !empty;
    end

    // Sample register and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_data   <= '0;
            stab_cnt <= '0;
        end else begin
            s_data   <= lat_data;
            stab_cnt <= cnt_next;
        end
    end

    // Reader FSM; dropping enable always returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (!lat_en) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    state <= SETTLE;
                SETTLE:  if (push) state <= HELD;
                HELD:    if (!match) state <= SETTLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overflow when an accepted word finds the FIFO full with no pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    latch_reader_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (lat_data),
        .pop   (pop),
        .rdata (out_data),
        .count (count),
        .full  (full),
        .empty (empty),
        .valid (out_valid)
    );

endmodule

// File: tb/tb_latch_reader.sv
// Directed bench for latch_reader with hand-computed expectations.
module tb_latch_reader;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             lat_en = 1'b0;
    logic [WIDTH-1:0] lat_data = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       count;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    latch_reader #(
        .WIDTH  (WIDTH),
        .STABLE (2),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lat_en    (lat_en),
        .lat_data  (lat_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [2:0] c,
                             input logic [31:0] d, input logic o);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_count"}, 32'(count), 32'(c));
        check({tag, "_data"}, out_data, d);
        check({tag, "_ovf"}, 32'(overflow), 32'(o));
    endtask

    // Hold a value long enough (3 edges) for one accept at STABLE=2.
    task automatic put_word(input logic [31:0] v);
        lat_data = v;
        cyc(3);
    endtask

    initial begin
        // Power-up reset
        cyc(2);
        check_all("rst0", 1'b0, 3'd0, 32'h0, 1'b0);

        // Single word: accepted exactly at edge 2, never re-pushed
        rst_n = 1'b1;
        lat_en = 1'b1;
        lat_data = 32'hA5A5_A5A5;
        out_ready = 1'b0;
        cyc(1);
        check("single_e0_count", 32'(count), 32'd0);
        cyc(1);
        check("single_e1_valid", 32'(out_valid), 32'd0);
        cyc(1);
        check_all("single_e2", 1'b1, 3'd1, 32'hA5A5_A5A5, 1'b0);
        cyc(3);
        check("single_hold_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        check("single_pop_count", 32'(count), 32'd0);
        check("single_pop_valid", 32'(out_valid), 32'd0);

        // Glitch rejection: alternating data never settles
        for (int i = 0; i < 10; i++) begin
            lat_data = (i % 2 == 0) ? 32'h1 : 32'h2;
            cyc(1);
        end
        check("glitch_count", 32'(count), 32'd0);
        cyc(1);
        check("glitch_first_match", 32'(count), 32'd0);
        cyc(1);
        check_all("glitch_settled", 1'b1, 3'd1, 32'h2, 1'b0);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        check("glitch_drain", 32'(count), 32'd0);

        // Full FIFO with simultaneous pop and push
        for (int v = 32'h11; v <= 32'h14; v++) put_word(32'(v));
        check_all("full", 1'b1, 3'd4, 32'h11, 1'b0);
        lat_data = 32'h15;
        cyc(2);
        check("full_pre_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        check_all("full_pushpop", 1'b1, 3'd4, 32'h12, 1'b0);
        out_ready = 1'b1;
        for (int v = 32'h12; v <= 32'h15; v++) begin
            check("full_order", out_data, 32'(v));
            cyc(1);
        end
        out_ready = 1'b0;
        check("full_drained", 32'(count), 32'd0);

        // Overflow: fifth word dropped, sticky flag set
        for (int v = 1; v <= 5; v++) put_word(32'(v));
        check_all("ovf", 1'b1, 3'd4, 32'h1, 1'b1);
        out_ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            check("ovf_order", out_data, 32'(v));
            cyc(1);
        end
        out_ready = 1'b0;
        check_all("ovf_drained", 1'b0, 3'd0, 32'h4, 1'b1);

        // Enable cycling: same value re-accepted, disabled zero never pushed
        put_word(32'hDEAD_BEEF);
        check("en_first", 32'(count), 32'd1);
        lat_en = 1'b0;
        lat_data = 32'h0;
        cyc(3);
        check("en_off_count", 32'(count), 32'd1);
        lat_en = 1'b1;
        lat_data = 32'hDEAD_BEEF;
        cyc(2);
        check("en_settling", 32'(count), 32'd1);
        cyc(1);
        check_all("en_second", 1'b1, 3'd2, 32'hDEAD_BEEF, 1'b1);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        check_all("en_popped", 1'b1, 3'd1, 32'hDEAD_BEEF, 1'b1);

        // Asynchronous reset mid-cycle with buffered data
        #3;
        rst_n = 1'b0;
        lat_data = $urandom;
        out_ready = 1'($urandom_range(0, 1));
        #1;
        check_all("rst_async", 1'b0, 3'd0, 32'h0, 1'b0);
        cyc(1);
        check_all("rst_held", 1'b0, 3'd0, 32'h0, 1'b0);

        // Resume from IDLE after reset release
        rst_n = 1'b1;
        lat_en = 1'b1;
        lat_data = 32'h77;
        out_ready = 1'b0;
        cyc(2);
        check("resume_settling", 32'(count), 32'd0);
        cyc(1);
        check_all("resume", 1'b1, 3'd1, 32'h77, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/latch_reader.md
# latch_reader

Reader-side companion to the enable-gated transparent data latch. It samples the latch output `lat_data` and the latch enable `lat_en` on the system clock. A word is accepted only after it has stayed unchanged for a programmable number of cycles. Accepted words are buffered in a small FIFO and presented downstream on a valid/ready handshake. The block sits directly after the latch wrapper and turns level-sensitive latch contents into a clean, one-word-per-change stream.

## Interface
- `WIDTH`, 32, data width; must match the latch width.
- `STABLE`, 2, consecutive matching clock edges required before a word is accepted; range 1..15.
- `DEPTH`, 4, number of FIFO entries; power of two, at least 2.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `lat_en`  in  1  latch enable, as driven to the latch.
- `lat_data`  in  WIDTH  latch output.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  downstream accepts the head word.
- `out_data`  out  WIDTH  FIFO head word.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky flag; set when an accepted word is dropped because the FIFO is full.

## Operation
- **Sample register.** `s_data <= lat_data` on every edge.
- **Stability counter `stab_cnt`** (4 bits):
  - increments, saturating at STABLE, on an edge where `lat_en=1` and `lat_data==s_data`;
  - clears to 0 on any other edge.
- **FSM states.** IDLE, SETTLE, HELD.
  - IDLE: `lat_en=0`. Goes to SETTLE on an edge with `lat_en=1`.
  - SETTLE: counting. When `stab_cnt` reaches STABLE on this edge, push `lat_data` and go to HELD.
  - HELD: word already accepted. Goes to SETTLE when `lat_data!=s_data`. No re-push while the value is unchanged.
  - Any state goes to IDLE when `lat_en=0`; `stab_cnt` clears.
- The latch outputs 0 while disabled. That zero is never pushed.
- Re-enabling with the same value as the last accepted word pushes it again. Every enable episode yields at least one word if the data settles.
- **FIFO.**
  - Pop when `out_valid && out_ready`.
  - Push when full and no pop on the same edge: the word is dropped and `overflow` is set.
  - Push and pop on the same edge while full: both succeed, `count` is unchanged, no overflow.
  - Push and pop on the same edge while empty: the pushed word is stored and the pop is ignored, since `out_valid` was 0.
  - Read/write pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH.
- **Overflow.** `overflow` clears only on reset.

## Timing
- Reset values, asserted immediately on `rst_n` low, independent of `clk`: `out_valid=0`, `out_data=0`, `count=0`, `overflow=0`. State is IDLE, `stab_cnt=0`, pointers 0, `s_data=0`.
- **Latency.** Suppose a new value V is first present before edge k with `lat_en=1`. Then:
  - it is pushed at edge k+STABLE;
  - `out_valid` and `out_data=V` are visible after that edge.
- If the value changes before edge k+STABLE, the counter restarts from the change.
- **Downstream handshake.**
  - `out_data` is the registered FIFO head and is stable while `out_valid=1` and `out_ready=0`.
  - The next word, if any, appears the cycle after a pop.
- **Reset mid-operation.** In-flight counts and buffered words are discarded. Operation resumes in IDLE on the first edge after `rst_n` rises.

## Structure
- **Package `latch_if_pkg`.** Holds:
  - the state enum `lr_state_t` {IDLE, SETTLE, HELD};
  - localparam `STAB_W=4`;
  - the function `clog2_min1` for pointer widths.
- **Sub-module `latch_reader_fifo`.** Parameterised synchronous FIFO with `WIDTH` and `DEPTH`, ports push/pop/full/empty/count, registered head output.
- **Top module.** Contains the sampler, counter, FSM and overflow flag.

## Test plan
- **Reset.** Drive `rst_n=0` mid-clock with random inputs → `out_valid=0`, `count=0`, `overflow=0`, `out_data=0` without waiting for an edge.
- **Single word.** STABLE=2, `lat_en=1`, `lat_data=32'hA5A5_A5A5` held from before edge 0 for 6 cycles, `out_ready=0` → exactly one push at edge 2, `count=1`, `out_data=32'hA5A5_A5A5`. Raise `out_ready` → `count=0` one edge later.
- **Glitch rejection.** `lat_data` toggles between 32'h1 and 32'h2 every cycle for 10 cycles → no push, `count=0`. It then holds 32'h2 → one push after 2 matching edges.
- **Overflow.** `out_ready=0`, five distinct values 1..5, each held 3 cycles → `count=4`, `overflow=1`. Draining yields 1,2,3,4; value 5 is absent.
- **Full with simultaneous pop.** FIFO full, `out_ready=1` on the same edge a sixth word is accepted → `count` stays 4, `overflow` unchanged, order preserved.
- **Enable cycling.** Value 32'hDEAD_BEEF accepted, `lat_en` low for 3 cycles (data 0), then high again with 32'hDEAD_BEEF → two entries of 32'hDEAD_BEEF, no zero entry.
